// File: rtl/axi_lite_param_regs.sv
// AXI4-Lite register file: CTRL/STATUS at 0x00, NUM_PARAMS parameter words from 0x04.
// Parameters and the start pulse feed the accelerator's stream datapath.
module axi_lite_param_regs #(
    parameter int NUM_PARAMS = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [31:0]             AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [31:0]             WDATA,
    input  logic [3:0]              WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [31:0]             ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [31:0]             RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [32*NUM_PARAMS-1:0] cfg_params,
    output logic                    cfg_start,
    input  logic                    core_done,
    input  logic                    core_idle
);

    localparam logic [29:0] LAST_IDX = 30'(NUM_PARAMS);
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic        aw_full;
    logic        w_full;
    logic [29:0] aw_idx;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic [31:0] params [NUM_PARAMS];
    logic        done;

    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        commit;
    logic        wr_ctrl;
    logic        wr_in_range;
    logic [29:0] rd_idx;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    // Byte lanes are dropped from the index; keep them visibly consumed.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] wd,
                                                input logic [3:0] strb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
        end
        return res;
    endfunction

    assign AWREADY = reset_n && !aw_full && !BVALID;
    assign WREADY  = reset_n && !w_full && !BVALID;
    assign ARREADY = reset_n && !RVALID;

    assign aw_hs       = AWVALID && AWREADY;
    assign w_hs        = WVALID && WREADY;
    assign ar_hs       = ARVALID && ARREADY;
    assign commit      = aw_full && w_full && !BVALID;
    assign wr_ctrl     = (aw_idx == 30'd0);
    assign wr_in_range = (aw_idx <= LAST_IDX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_idx    <= '0;
            w_data    <= '0;
            w_strb    <= '0;
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
            cfg_start <= 1'b0;
        end else begin
            cfg_start <= commit && wr_ctrl && w_strb[0] && w_data[0];
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= AWADDR[31:2];
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= WDATA;
                w_strb <= WSTRB;
            end
            if (BVALID && BREADY) BVALID <= 1'b0;
            // Handshakes cannot coincide with commit: both buffers full blocks the readies.
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                BVALID  <= 1'b1;
                BRESP   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PARAMS; i++) params[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                if (aw_idx == 30'(i + 1)) params[i] <= merge_bytes(params[i], w_data, w_strb);
            end
        end
    end

    // A completion pulse outranks a simultaneous software clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done <= 1'b0;
        end else if (core_done) begin
            done <= 1'b1;
        end else if (commit && wr_ctrl && w_strb[0] && w_data[1]) begin
            done <= 1'b0;
        end
    end

    assign rd_idx = ARADDR[31:2];

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        if (rd_idx == 30'd0) begin
            rd_data = {29'd0, core_idle, done, 1'b0};
            rd_resp = RESP_OKAY;
        end else begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                if (rd_idx == 30'(i + 1)) begin
                    rd_data = params[i];
                    rd_resp = RESP_OKAY;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= RESP_OKAY;
        end else if (ar_hs) begin
            RVALID <= 1'b1;
            RDATA  <= rd_data;
            RRESP  <= rd_resp;
        end else if (RVALID && RREADY) begin
            RVALID <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_cfg
        assign cfg_params[32*g +: 32] = params[g];
    end

endmodule

// File: tb/tb_axi_lite_param_regs.sv
// Directed bench for axi_lite_param_regs: write/read paths, CTRL start/done, errors, reset.
module tb_axi_lite_param_regs;

    localparam int NP = 8;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [31:0]     AWADDR;
    logic            AWVALID;
    logic            AWREADY;
    logic [31:0]     WDATA;
    logic [3:0]      WSTRB;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [31:0]     ARADDR;
    logic            ARVALID;
    logic            ARREADY;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;
    logic [32*NP-1:0] cfg_params;
    logic            cfg_start;
    logic            core_done;
    logic            core_idle;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] exp_p [NP];
    logic [31:0] rd_d;
    logic [1:0]  rd_r;
    logic [1:0]  wr_r;

    always #5 clock = ~clock;

    axi_lite_param_regs #(.NUM_PARAMS(NP)) dut (
        .clock(clock), .reset_n(reset_n),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .cfg_params(cfg_params), .cfg_start(cfg_start),
        .core_done(core_done), .core_idle(core_idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
        logic aw_rdy, w_rdy;
        bit aw_done, w_done, b_done;
        aw_done = 0; w_done = 0; b_done = 0;
        resp = 2'bxx;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
            aw_rdy = AWREADY;
            w_rdy  = WREADY;
            tick();
            if (aw_rdy && AWVALID) begin AWVALID = 1'b0; aw_done = 1; end
            if (w_rdy && WVALID) begin WVALID = 1'b0; w_done = 1; end
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("wr_handshake", {31'd0, aw_done && w_done}, 32'd1);
        for (int c = 0; c < 20 && !b_done; c++) begin
            if (BVALID) begin
                resp = BRESP;
                b_done = 1;
            end
            tick();
        end
        chk("wr_bvalid_seen", {31'd0, b_done}, 32'd1);
    endtask

    task automatic axi_rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic ar_rdy;
        bit ar_done, r_done;
        ar_done = 0; r_done = 0;
        data = 'x; resp = 'x;
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b0;
        for (int c = 0; c < 20 && !ar_done; c++) begin
            ar_rdy = ARREADY;
            tick();
            if (ar_rdy) begin ARVALID = 1'b0; ar_done = 1; end
        end
        ARVALID = 1'b0;
        for (int c = 0; c < 20 && !r_done; c++) begin
            if (RVALID) begin
                data = RDATA; resp = RRESP; r_done = 1;
            end else begin
                tick();
            end
        end
        chk("rd_rvalid_seen", {31'd0, r_done}, 32'd1);
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        chk("rd_rvalid_clear", {31'd0, RVALID}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0; core_done = 1'b0; core_idle = 1'b0;
        for (int i = 0; i < NP; i++) exp_p[i] = '0;

        // Reset state
        #2;
        chk("rst_awready", {31'd0, AWREADY}, 32'd0);
        chk("rst_wready", {31'd0, WREADY}, 32'd0);
        chk("rst_arready", {31'd0, ARREADY}, 32'd0);
        chk("rst_bvalid", {31'd0, BVALID}, 32'd0);
        chk("rst_rvalid", {31'd0, RVALID}, 32'd0);
        chk("rst_cfg_start", {31'd0, cfg_start}, 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_bresp_rresp", {28'd0, BRESP, RRESP}, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_readies", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);

        // PARAM[2] with AW and W in the same cycle
        AWADDR = 32'h0C; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("t1_bvalid_n", {31'd0, BVALID}, 32'd0);
        chk("t1_readies_full", {30'd0, AWREADY, WREADY}, 32'd0);
        tick();
        chk("t1_bvalid_n1", {31'd0, BVALID}, 32'd1);
        chk("t1_bresp", {30'd0, BRESP}, 32'd0);
        chk("t1_cfg_p2", cfg_params[95:64], 32'hDEADBEEF);
        tick();
        chk("t1_bvalid_done", {31'd0, BVALID}, 32'd0);
        exp_p[2] = 32'hDEADBEEF;

        ARADDR = 32'h0C; ARVALID = 1'b1; RREADY = 1'b0;
        chk("t1_arready", {31'd0, ARREADY}, 32'd1);
        tick();
        ARVALID = 1'b0;
        chk("t1_rvalid", {31'd0, RVALID}, 32'd1);
        chk("t1_rdata", RDATA, 32'hDEADBEEF);
        chk("t1_rresp", {30'd0, RRESP}, 32'd0);
        chk("t1_arready_busy", {31'd0, ARREADY}, 32'd0);
        tick();
        chk("t1_rvalid_hold", {31'd0, RVALID}, 32'd1);
        chk("t1_rdata_hold", RDATA, 32'hDEADBEEF);
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        chk("t1_rvalid_clear", {31'd0, RVALID}, 32'd0);

        // W ahead of AW with a partial strobe
        axi_wr(32'h04, 32'h11223344, 4'hF, wr_r);
        chk("t2_init_resp", {30'd0, wr_r}, 32'd0);
        WDATA = 32'h0000AB00; WSTRB = 4'b0010; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("t2_wready_full", {31'd0, WREADY}, 32'd0);
        chk("t2_awready_open", {31'd0, AWREADY}, 32'd1);
        repeat (3) tick();
        chk("t2_gap_ready", {30'd0, AWREADY, WREADY}, 32'd2);
        chk("t2_gap_bvalid", {31'd0, BVALID}, 32'd0);
        AWADDR = 32'h04; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("t2_bvalid_n", {31'd0, BVALID}, 32'd0);
        tick();
        chk("t2_bvalid_n1", {31'd0, BVALID}, 32'd1);
        chk("t2_cfg_p0", cfg_params[31:0], 32'h1122AB44);
        tick();
        exp_p[0] = 32'h1122AB44;
        axi_rd(32'h04, rd_d, rd_r);
        chk("t2_read_p0", rd_d, 32'h1122AB44);

        // Back-pressure on B blocks new write traffic
        AWADDR = 32'h08; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        chk("t3_bvalid", {31'd0, BVALID}, 32'd1);
        AWADDR = 32'h10; WDATA = 32'h12345678; AWVALID = 1'b1; WVALID = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3_hold_bvalid", {31'd0, BVALID}, 32'd1);
            chk("t3_hold_readies", {30'd0, AWREADY, WREADY}, 32'd0);
        end
        chk("t3_p3_untouched", cfg_params[127:96], 32'd0);
        BREADY = 1'b1;
        tick();
        chk("t3_bvalid_clr", {31'd0, BVALID}, 32'd0);
        chk("t3_awready_back", {31'd0, AWREADY}, 32'd1);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("t3_bvalid_n", {31'd0, BVALID}, 32'd0);
        tick();
        chk("t3_bvalid_2nd", {31'd0, BVALID}, 32'd1);
        chk("t3_cfg_p3", cfg_params[127:96], 32'h12345678);
        chk("t3_cfg_p1", cfg_params[63:32], 32'hA5A5A5A5);
        tick();
        exp_p[1] = 32'hA5A5A5A5;
        exp_p[3] = 32'h12345678;

        // START pulse
        AWADDR = 32'h00; WDATA = 32'h1; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("t4_start_n", {31'd0, cfg_start}, 32'd0);
        tick();
        chk("t4_start_n1", {31'd0, cfg_start}, 32'd1);
        tick();
        chk("t4_start_n2", {31'd0, cfg_start}, 32'd0);
        axi_rd(32'h00, rd_d, rd_r);
        chk("t4_ctrl_after_start", rd_d, 32'h0);

        // DONE sticky, IDLE live, W1C rules
        core_idle = 1'b1; core_done = 1'b1;
        tick();
        core_done = 1'b0;
        axi_rd(32'h00, rd_d, rd_r);
        chk("t4_ctrl_done_idle", rd_d, 32'h6);
        core_idle = 1'b0;
        axi_rd(32'h00, rd_d, rd_r);
        chk("t4_ctrl_done", rd_d, 32'h2);
        axi_wr(32'h00, 32'h2, 4'b0010, wr_r);
        axi_rd(32'h00, rd_d, rd_r);
        chk("t4_w1c_no_strb0", rd_d, 32'h2);
        AWADDR = 32'h00; WDATA = 32'h2; WSTRB = 4'b0001; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        axi_rd(32'h00, rd_d, rd_r);
        chk("t4_set_wins", rd_d, 32'h2);
        axi_wr(32'h00, 32'h2, 4'b0001, wr_r);
        axi_rd(32'h00, rd_d, rd_r);
        chk("t4_w1c_cleared", rd_d, 32'h0);

        // Range boundaries
        axi_wr(32'h20, 32'hCAFEF00D, 4'hF, wr_r);
        chk("t5_last_resp", {30'd0, wr_r}, 32'd0);
        exp_p[7] = 32'hCAFEF00D;
        axi_wr(32'h24, 32'hFFFFFFFF, 4'hF, wr_r);
        chk("t5_oor_bresp", {30'd0, wr_r}, 32'd2);
        axi_rd(32'h24, rd_d, rd_r);
        chk("t5_oor_rdata", rd_d, 32'd0);
        chk("t5_oor_rresp", {30'd0, rd_r}, 32'd2);
        axi_rd(32'h0F, rd_d, rd_r);
        chk("t5_lsb_ignored", rd_d, 32'hDEADBEEF);
        for (int i = 0; i < NP; i++) chk("t5_params", cfg_params[32*i +: 32], exp_p[i]);

        // Reset with B and R both pending
        AWADDR = 32'h04; WDATA = 32'h99; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        ARADDR = 32'h0C; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        ARVALID = 1'b0;
        chk("t6_pending", {30'd0, BVALID, RVALID}, 32'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_bvalid_drop", {31'd0, BVALID}, 32'd0);
        chk("t6_rvalid_drop", {31'd0, RVALID}, 32'd0);
        chk("t6_readies_low", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        BREADY = 1'b1;
        for (int i = 0; i < NP; i++) begin
            axi_rd(32'(4 * (i + 1)), rd_d, rd_r);
            chk("t6_param_zero", rd_d, 32'd0);
        end
        chk("t6_no_stale_b", {31'd0, BVALID}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_param_regs.md
Name: axi_lite_param_regs

Overview:
- AXI4-Lite responder (slave) register file that terminates the configuration master's write/read traffic for an HLS accelerator.
- Holds NUM_PARAMS 32-bit run-time parameters plus a control/status register.
- Drives the parameters and a start pulse into the stream datapath, and reports completion back to software.

Parameters:
NUM_PARAMS, 8, number of 32-bit read/write parameter registers (1..64)

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
AWADDR  in  32  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  32  write data
WSTRB  in  4  write byte strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  32  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  32  read data
RRESP  out  2  read response
RVALID  out  1  read valid
RREADY  in  1  read ready
cfg_params  out  32*NUM_PARAMS  parameter i at bits [32i+31:32i]
cfg_start  out  1  one-cycle start pulse to the datapath
core_done  in  1  one-cycle completion pulse from the datapath
core_idle  in  1  datapath idle level

Behaviour:
- Register map (index = ADDR[31:2]; ADDR[1:0] ignored):
  - 0x00 CTRL:
    - bit0 START: write-1 pulses cfg_start; reads 0.
    - bit1 DONE: sticky, set by core_done; write-1-to-clear.
    - bit2 IDLE: read-only, equals core_idle.
    - Other bits read 0.
  - 0x04+4i PARAM[i]: read/write, i < NUM_PARAMS.
  - Index > NUM_PARAMS: out of range.
- Reset (async assert, sync-safe release):
  - All PARAM, DONE, aw_full, w_full, BVALID, RVALID = 0.
  - cfg_start = 0; BRESP = RRESP = 00; RDATA = 0.
  - AWREADY, WREADY, ARREADY forced 0 while reset_n low.
  - Reset mid-transaction drops it silently; no response is issued.
- Write channel:
  - AW and W are accepted independently, in either order or the same cycle.
  - AWREADY = !aw_full && !BVALID.
  - WREADY = !w_full && !BVALID.
  - Accepted AWADDR and WDATA/WSTRB are latched into aw_full / w_full.
- Write commit:
  - Occurs at the edge where aw_full && w_full && !BVALID.
  - On that edge: bytes with WSTRB[b]=1 update, BVALID<=1, aw_full and w_full clear.
  - Latency: AW and W both handshaken at edge N → commit and BVALID at edge N+1.
  - BVALID holds until BREADY; no new AW/W is accepted while BVALID is high.
- Write response: BRESP = 00 OKAY in range; 10 SLVERR out of range (no state change).
- CTRL writes:
  - START acts only if WSTRB[0] and WDATA[0]; cfg_start is high exactly the cycle after commit.
  - DONE clears only if WSTRB[0] and WDATA[1].
  - core_done in the same cycle as a DONE clear → set wins.
- Read channel:
  - ARREADY = !RVALID.
  - On AR handshake at edge N: RDATA and RRESP register the current (pre-commit) values, and RVALID = 1 from N.
  - RDATA, RRESP and RVALID hold stable until RREADY; RVALID clears on the RREADY edge.
  - Out of range reads return RDATA = 0, RRESP = 10.
  - Back-to-back reads give one transfer per 2 cycles minimum.
- Concurrency:
  - Read and write channels are fully independent.
  - A read of a register committed on the same edge returns the old value.
- cfg_params are driven directly from the registers; a change is visible the cycle after commit.

Test Plan:
- Reset, then write PARAM[2]=0xDEADBEEF with AW and W in the same cycle, BREADY=1 → BVALID one cycle later with BRESP=00; cfg_params[95:64]=0xDEADBEEF; read 0x0C returns 0xDEADBEEF with RRESP=00.
- W before AW (3-cycle gap), WSTRB=0b0010, WDATA=0x0000AB00 on PARAM[0]=0x11223344 → PARAM[0]=0x1122AB44; AWREADY stays high, WREADY low while w_full.
- BREADY held low 5 cycles after a write → BVALID stays high; AWREADY/WREADY stay low; a second AW is not accepted until BREADY.
- Write CTRL=0x1 → cfg_start high exactly 1 cycle; core_done pulse → read CTRL=0x2 (|0x4 if core_idle=1); core_done and W1C DONE in the same cycle → DONE remains 1.
- Write and read to address 4*(NUM_PARAMS+1)=0x24 → BRESP=10, no register change; RDATA=0, RRESP=10.
- Assert reset_n=0 while BVALID and RVALID are pending → both drop to 0 immediately; all params read 0 after release.
